// File: rtl/ps2_mouse_packet_rx.sv
// PS/2 mouse receive front end: conditions the raw lines, deserializes 11-bit frames,
// assembles 3-byte movement packets and tracks a clamped cursor position.
module ps2_mouse_packet_rx #(
    parameter int TIMEOUT_CYCLES = 10000,
    parameter int POS_MAX_X      = 639,
    parameter int POS_MAX_Y      = 479
) (
    input  logic       ACLK,
    input  logic       ARESET,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       clear_pos,
    output logic       pkt_valid,
    output logic [2:0] btn,
    output logic [8:0] dx,
    output logic [8:0] dy,
    output logic [1:0] ovf,
    output logic [9:0] pos_x,
    output logic [9:0] pos_y,
    output logic       frame_err,
    output logic [7:0] err_cnt
);

    localparam int                  TMO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0]    TMO_LIM = TMO_W'(TIMEOUT_CYCLES);
    localparam logic [9:0]          CTR_X   = 10'(POS_MAX_X / 2);
    localparam logic [9:0]          CTR_Y   = 10'(POS_MAX_Y / 2);
    localparam logic signed [11:0]  MAX_X_S = 12'(POS_MAX_X);
    localparam logic signed [11:0]  MAX_Y_S = 12'(POS_MAX_Y);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    function automatic logic [9:0] clamp_pos(input logic signed [11:0] v,
                                             input logic signed [11:0] hi);
        if (v < 12'sd0)
            return 10'd0;
        else if (v > hi)
            return hi[9:0];
        else
            return v[9:0];
    endfunction

    logic [1:0] clk_sync;
    logic [1:0] dat_sync;
    logic       clk_s;
    logic       data_bit;
    logic       filt_clk;
    logic [1:0] filt_cnt;
    logic       strobe;

    state_t           state;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;
    logic             par_bit;
    logic [TMO_W-1:0] tmo_cnt;

    logic             tmo_hit;
    logic             stop_ev;
    logic             byte_ok;
    logic             err_ev;

    logic [1:0]       idx;
    logic [2:0]       hdr_btn;
    logic [3:0]       hdr_hi;
    logic [7:0]       byte_x;

    logic signed [8:0]  dx_new;
    logic signed [8:0]  dy_new;
    logic signed [11:0] sum_x;
    logic signed [11:0] sum_y;
    logic [9:0]         px_next;
    logic [9:0]         py_next;

    assign clk_s    = clk_sync[1];
    assign data_bit = dat_sync[1];

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
        end
    end

    // Filtered clock follows the synchronized line only after four agreeing samples.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            filt_clk <= 1'b1;
            filt_cnt <= 2'd0;
        end else if (clk_s == filt_clk) begin
            filt_cnt <= 2'd0;
        end else if (filt_cnt == 2'd3) begin
            filt_clk <= clk_s;
            filt_cnt <= 2'd0;
        end else begin
            filt_cnt <= filt_cnt + 2'd1;
        end
    end

    assign strobe = filt_clk & ~clk_s & (filt_cnt == 2'd3);

    always_comb begin
        tmo_hit = (state != IDLE) && !strobe && (tmo_cnt == TMO_LIM);
        stop_ev = strobe && (state == STOP);
        byte_ok = stop_ev && data_bit && (^{shreg, par_bit});
        err_ev  = (stop_ev && !byte_ok) || tmo_hit;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state   <= IDLE;
            bit_cnt <= 3'd0;
            tmo_cnt <= '0;
        end else begin
            if (state == IDLE || strobe)
                tmo_cnt <= '0;
            else
                tmo_cnt <= tmo_cnt + 1'b1;

            if (tmo_hit) begin
                state <= IDLE;
            end else if (strobe) begin
                case (state)
                    IDLE: begin
                        if (!data_bit) begin
                            state   <= DATA;
                            bit_cnt <= 3'd0;
                        end
                    end
                    DATA: begin
                        shreg   <= {data_bit, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7)
                            state <= PARITY;
                    end
                    PARITY: begin
                        par_bit <= data_bit;
                        state   <= STOP;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // The third byte is still in the shift register when the packet completes.
    always_comb begin
        dx_new  = {hdr_hi[0], byte_x};
        dy_new  = {hdr_hi[1], shreg};
        sum_x   = $signed({2'b00, pos_x}) + {{3{dx_new[8]}}, dx_new};
        sum_y   = $signed({2'b00, pos_y}) - {{3{dy_new[8]}}, dy_new};
        px_next = clamp_pos(sum_x, MAX_X_S);
        py_next = clamp_pos(sum_y, MAX_Y_S);
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            idx       <= 2'd0;
            pkt_valid <= 1'b0;
            frame_err <= 1'b0;
            err_cnt   <= 8'd0;
            btn       <= 3'd0;
            dx        <= 9'd0;
            dy        <= 9'd0;
            ovf       <= 2'd0;
            pos_x     <= CTR_X;
            pos_y     <= CTR_Y;
        end else begin
            pkt_valid <= 1'b0;
            frame_err <= err_ev;
            if (err_ev) begin
                idx <= 2'd0;
                if (err_cnt != 8'hFF)
                    err_cnt <= err_cnt + 8'd1;
            end else if (byte_ok) begin
                case (idx)
                    2'd0: begin
                        if (shreg[3]) begin
                            hdr_btn <= shreg[2:0];
                            hdr_hi  <= shreg[7:4];
                            idx     <= 2'd1;
                        end
                    end
                    2'd1: begin
                        byte_x <= shreg;
                        idx    <= 2'd2;
                    end
                    2'd2: begin
                        btn       <= hdr_btn;
                        dx        <= dx_new;
                        dy        <= dy_new;
                        ovf       <= hdr_hi[3:2];
                        pkt_valid <= 1'b1;
                        idx       <= 2'd0;
                        if (!hdr_hi[2])
                            pos_x <= px_next;
                        if (!hdr_hi[3])
                            pos_y <= py_next;
                    end
                    default: idx <= 2'd0;
                endcase
            end
            // Recentring overrides any movement applied on the same edge.
            if (clear_pos) begin
                pos_x <= CTR_X;
                pos_y <= CTR_Y;
            end
        end
    end

endmodule

// File: tb/tb_ps2_mouse_packet_rx.sv
// Self-checking bench for ps2_mouse_packet_rx: PS/2 frame driver, packet-level model, scenario tasks.
`timescale 1ns/1ps
module tb_ps2_mouse_packet_rx;

    logic       ACLK = 1'b0;
    logic       ARESET = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       clear_pos = 1'b0;
    logic       pkt_valid;
    logic [2:0] btn;
    logic [8:0] dx;
    logic [8:0] dy;
    logic [1:0] ovf;
    logic [9:0] pos_x;
    logic [9:0] pos_y;
    logic       frame_err;
    logic [7:0] err_cnt;

    ps2_mouse_packet_rx #(.TIMEOUT_CYCLES(200), .POS_MAX_X(639), .POS_MAX_Y(479)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .clear_pos(clear_pos), .pkt_valid(pkt_valid), .btn(btn), .dx(dx), .dy(dy),
        .ovf(ovf), .pos_x(pos_x), .pos_y(pos_y), .frame_err(frame_err), .err_cnt(err_cnt)
    );

    always #5 ACLK = ~ACLK;

    int nchecks = 0;
    int nerrors = 0;

    // Observed pulse counts and the values captured at each pkt_valid
    int pkt_seen = 0;
    int err_seen = 0;
    int both_seen = 0;
    logic [2:0] cap_btn;
    logic [8:0] cap_dx, cap_dy;
    logic [1:0] cap_ovf;

    always @(negedge ACLK) begin
        if (pkt_valid) begin
            pkt_seen <= pkt_seen + 1;
            cap_btn  <= btn;
            cap_dx   <= dx;
            cap_dy   <= dy;
            cap_ovf  <= ovf;
        end
        if (frame_err) err_seen <= err_seen + 1;
        if (pkt_valid && frame_err) both_seen <= both_seen + 1;
    end

    // Packet-level reference model
    int m_idx, m_px, m_py, m_errc;
    logic [7:0] m_b0, m_b1;
    logic [2:0] e_btn;
    int e_dx, e_dy;
    logic [1:0] e_ovf;
    int exp_pkts = 0;
    int exp_errs = 0;

    function automatic int clampi(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic model_reset();
        m_idx = 0; m_px = 319; m_py = 239; m_errc = 0;
    endtask

    task automatic model_err();
        m_idx = 0;
        if (m_errc < 255) m_errc++;
        exp_errs++;
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (m_idx == 0) begin
            if (b[3]) begin m_b0 = b; m_idx = 1; end
        end else if (m_idx == 1) begin
            m_b1 = b; m_idx = 2;
        end else begin
            e_btn = m_b0[2:0];
            e_dx  = int'(m_b1) - (m_b0[4] ? 256 : 0);
            e_dy  = int'(b) - (m_b0[5] ? 256 : 0);
            e_ovf = m_b0[7:6];
            if (!m_b0[6]) m_px = clampi(m_px + e_dx, 639);
            if (!m_b0[7]) m_py = clampi(m_py - e_dy, 479);
            m_idx = 0;
            exp_pkts++;
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge ACLK);
    endtask

    // Drives nbits of an 11-bit frame, 20-cycle half periods; optionally holds clear_pos
    // across the stop-bit strobe and drops it once pkt_valid is observed.
    task automatic send_frame(input logic [7:0] b, input bit flip_par, input int nbits, input bit clr);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ flip_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = fr[i];
            wait_cyc(10);
            if (clr && i == 10) clear_pos = 1'b1;
            ps2_clk = 1'b0;
            for (int k = 0; k < 20; k++) begin
                @(negedge ACLK);
                if (clear_pos && pkt_valid) clear_pos = 1'b0;
            end
            clear_pos = 1'b0;
            ps2_clk = 1'b1;
            wait_cyc(10);
        end
        ps2_data = 1'b1;
        wait_cyc(20);
    endtask

    task automatic tx_byte(input logic [7:0] b);
        send_frame(b, 1'b0, 11, 1'b0);
        model_byte(b);
    endtask

    task automatic tx_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input bit clr);
        tx_byte(b0);
        tx_byte(b1);
        send_frame(b2, 1'b0, 11, clr);
        model_byte(b2);
        if (clr) begin m_px = 319; m_py = 239; end
    endtask

    task automatic do_reset();
        ARESET = 1'b1;
        wait_cyc(3);
        ARESET = 1'b0;
        model_reset();
        wait_cyc(2);
    endtask

    task automatic test_reset();
        do_reset();
        nchecks++;
        if ({pkt_valid, frame_err, btn, dx, dy, ovf, err_cnt} !== 33'd0) begin
            nerrors++;
            $display("FAIL reset_outputs: got %h want 0", {pkt_valid, frame_err, btn, dx, dy, ovf, err_cnt});
        end
        nchecks++;
        if (pos_x !== 10'd319 || pos_y !== 10'd239) begin
            nerrors++;
            $display("FAIL reset_pos: got %0d/%0d want 319/239", pos_x, pos_y);
        end
    endtask

    task automatic test_basic();
        int p0;
        do_reset();
        p0 = pkt_seen;
        tx_packet(8'h29, 8'h05, 8'hFE, 1'b0);
        nchecks++;
        if (pkt_seen - p0 !== 1) begin
            nerrors++;
            $display("FAIL basic_count: got %0d want 1", pkt_seen - p0);
        end
        nchecks++;
        if ({cap_btn, cap_dx, cap_dy, cap_ovf} !== {3'b001, 9'd5, 9'h1FE, 2'b00}) begin
            nerrors++;
            $display("FAIL basic_fields: got btn=%b dx=%h dy=%h ovf=%b want 001/005/1fe/00", cap_btn, cap_dx, cap_dy, cap_ovf);
        end
        nchecks++;
        if (pos_x !== 10'd324 || pos_y !== 10'd241) begin
            nerrors++;
            $display("FAIL basic_pos: got %0d/%0d want 324/241", pos_x, pos_y);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        tx_packet(8'h18, 8'h00, 8'h00, 1'b0);
        nchecks++;
        if (cap_dx !== 9'h100 || pos_x !== 10'd63 || pos_y !== 10'd239) begin
            nerrors++;
            $display("FAIL sat_first: got dx=%h pos=%0d/%0d want 100 63/239", cap_dx, pos_x, pos_y);
        end
        tx_packet(8'h18, 8'h00, 8'h00, 1'b0);
        nchecks++;
        if (cap_dx !== 9'h100 || pos_x !== 10'd0 || pos_y !== 10'd239) begin
            nerrors++;
            $display("FAIL sat_second: got dx=%h pos=%0d/%0d want 100 0/239", cap_dx, pos_x, pos_y);
        end
    endtask

    task automatic test_parity();
        int p0, e0;
        do_reset();
        p0 = pkt_seen; e0 = err_seen;
        send_frame(8'h29, 1'b1, 11, 1'b0);
        model_err();
        nchecks++;
        if (err_seen - e0 !== 1 || err_cnt !== 8'd1 || pkt_seen !== p0) begin
            nerrors++;
            $display("FAIL parity_err: got errs=%0d cnt=%0d pkts=%0d want 1/1/0", err_seen - e0, err_cnt, pkt_seen - p0);
        end
        tx_packet(8'h08, 8'h01, 8'h01, 1'b0);
        nchecks++;
        if (pkt_seen - p0 !== 1 || pos_x !== 10'd320 || pos_y !== 10'd238) begin
            nerrors++;
            $display("FAIL parity_recover: got pkts=%0d pos=%0d/%0d want 1 320/238", pkt_seen - p0, pos_x, pos_y);
        end
    endtask

    task automatic test_timeout();
        int p0, e0;
        do_reset();
        p0 = pkt_seen; e0 = err_seen;
        send_frame(8'h5A, 1'b0, 5, 1'b0);
        wait_cyc(300);
        model_err();
        nchecks++;
        if (err_seen - e0 !== 1 || err_cnt !== 8'd1) begin
            nerrors++;
            $display("FAIL timeout_err: got errs=%0d cnt=%0d want 1/1", err_seen - e0, err_cnt);
        end
        tx_packet(8'h08, 8'h01, 8'h01, 1'b0);
        nchecks++;
        if (pkt_seen - p0 !== 1 || pos_x !== 10'd320 || pos_y !== 10'd238 || err_seen - e0 !== 1) begin
            nerrors++;
            $display("FAIL timeout_recover: got pkts=%0d pos=%0d/%0d errs=%0d want 1 320/238 1",
                     pkt_seen - p0, pos_x, pos_y, err_seen - e0);
        end
    endtask

    task automatic test_resync();
        int p0;
        do_reset();
        p0 = pkt_seen;
        tx_byte(8'h00);
        tx_packet(8'h48, 8'h10, 8'h01, 1'b0);
        nchecks++;
        if (pkt_seen - p0 !== 1 || cap_ovf !== 2'b01 || pos_x !== 10'd319 || pos_y !== 10'd238) begin
            nerrors++;
            $display("FAIL resync: got pkts=%0d ovf=%b pos=%0d/%0d want 1 01 319/238", pkt_seen - p0, cap_ovf, pos_x, pos_y);
        end
    endtask

    task automatic test_clear();
        int p0;
        do_reset();
        p0 = pkt_seen;
        tx_packet(8'h08, 8'h7F, 8'h00, 1'b1);
        nchecks++;
        if (pkt_seen - p0 !== 1 || cap_dx !== 9'd127 || pos_x !== 10'd319 || pos_y !== 10'd239) begin
            nerrors++;
            $display("FAIL clear_pos: got pkts=%0d dx=%h pos=%0d/%0d want 1 07f 319/239", pkt_seen - p0, cap_dx, pos_x, pos_y);
        end
    endtask

    task automatic test_midreset();
        int p0, e0;
        do_reset();
        tx_byte(8'h09);
        tx_byte(8'h30);
        send_frame(8'hFF, 1'b0, 4, 1'b0);
        p0 = pkt_seen; e0 = err_seen;
        do_reset();
        wait_cyc(300);
        nchecks++;
        if (pkt_seen !== p0 || err_seen !== e0 || err_cnt !== 8'd0) begin
            nerrors++;
            $display("FAIL midreset_quiet: got pkts=%0d errs=%0d cnt=%0d want 0/0/0", pkt_seen - p0, err_seen - e0, err_cnt);
        end
        tx_packet(8'h08, 8'h02, 8'h00, 1'b0);
        nchecks++;
        if (pkt_seen - p0 !== 1 || pos_x !== 10'd321 || pos_y !== 10'd239) begin
            nerrors++;
            $display("FAIL midreset_fresh: got pkts=%0d pos=%0d/%0d want 1 321/239", pkt_seen - p0, pos_x, pos_y);
        end
    endtask

    task automatic test_random();
        logic [7:0] b0, b1, b2, s;
        do_reset();
        for (int n = 0; n < 14; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                s = 8'($urandom);
                s[3] = 1'b0;
                tx_byte(s);
            end
            b0 = 8'($urandom);
            b0[3] = 1'b1;
            if ($urandom_range(0, 3) != 0) b0[7:6] = 2'b00;
            b1 = 8'($urandom);
            b2 = 8'($urandom);
            tx_packet(b0, b1, b2, 1'b0);
            nchecks++;
            if (pkt_seen !== exp_pkts || {cap_btn, cap_dx, cap_dy, cap_ovf} !== {e_btn, 9'(e_dx), 9'(e_dy), e_ovf}) begin
                nerrors++;
                $display("FAIL random_pkt%0d: got n=%0d %b/%h/%h/%b want n=%0d %b/%h/%h/%b", n, pkt_seen,
                         cap_btn, cap_dx, cap_dy, cap_ovf, exp_pkts, e_btn, 9'(e_dx), 9'(e_dy), e_ovf);
            end
            nchecks++;
            if (pos_x !== 10'(m_px) || pos_y !== 10'(m_py)) begin
                nerrors++;
                $display("FAIL random_pos%0d: got %0d/%0d want %0d/%0d", n, pos_x, pos_y, m_px, m_py);
            end
        end
        nchecks++;
        if (err_seen !== exp_errs || both_seen !== 0) begin
            nerrors++;
            $display("FAIL pulse_totals: got errs=%0d overlap=%0d want %0d/0", err_seen, both_seen, exp_errs);
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_saturate();
        test_parity();
        test_timeout();
        test_resync();
        test_clear();
        test_midreset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
